// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared types and constants for the gray binarizer stage
package gray_pkg;
  localparam int GRAY_W = 8;

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_e;

  localparam logic [GRAY_W-1:0] BIN_ON  = 8'hFF;
  localparam logic [GRAY_W-1:0] BIN_OFF = 8'h00;
endpackage

// File: rtl/gray_frame_binarizer_if.sv
// rtl/gray_frame_binarizer_if.sv - pixel input and binarized output stream bundle
interface gray_frame_binarizer_if;
  import gray_pkg::*;

  logic              in_valid;
  logic [GRAY_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [GRAY_W-1:0] out_gray;
  logic [GRAY_W-1:0] out_bin;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_gray, out_bin, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_gray, out_bin, out_last
  );
endinterface

// File: rtl/gray_frame_stats.sv
// rtl/gray_frame_stats.sv - per-frame sum/min/max accumulators and pixel counter
module gray_frame_stats
  import gray_pkg::*;
#(
  parameter int FRAME_LOG2 = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              accept_i,
  input  logic [GRAY_W-1:0] pix_i,
  input  logic              clear_i,
  output logic              last_o,
  output logic [GRAY_W-1:0] min_o,
  output logic [GRAY_W-1:0] max_o,
  output logic [GRAY_W-1:0] mean_o
);
  localparam int SUM_W = GRAY_W + FRAME_LOG2;

  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [FRAME_LOG2-1:0] pix_cnt_q, pix_cnt_d;
  logic [GRAY_W-1:0]     min_q, min_d;
  logic [GRAY_W-1:0]     max_q, max_d;
  logic                  first;

  assign first  = (pix_cnt_q == '0);
  assign last_o = (pix_cnt_q == '1);
  assign min_o  = min_q;
  assign max_o  = max_q;
  assign mean_o = sum_q[SUM_W-1 -: GRAY_W];

  // First pixel of a frame seeds min/max so no sentinel value is needed.
  always_comb begin
    sum_d     = sum_q;
    pix_cnt_d = pix_cnt_q;
    min_d     = min_q;
    max_d     = max_q;
    if (clear_i) begin
      sum_d     = '0;
      pix_cnt_d = '0;
    end else if (accept_i) begin
      sum_d     = sum_q + SUM_W'(pix_i);
      pix_cnt_d = pix_cnt_q + FRAME_LOG2'(1);
      min_d     = (first || pix_i < min_q) ? pix_i : min_q;
      max_d     = (first || pix_i > max_q) ? pix_i : max_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q     <= '0;
      pix_cnt_q <= '0;
      min_q     <= '0;
      max_q     <= '0;
    end else begin
      sum_q     <= sum_d;
      pix_cnt_q <= pix_cnt_d;
      min_q     <= min_d;
      max_q     <= max_d;
    end
  end
endmodule

// File: rtl/gray_frame_binarizer.sv
// rtl/gray_frame_binarizer.sv - adaptive-threshold binarizer with per-frame statistics
module gray_frame_binarizer
  import gray_pkg::*;
#(
  parameter int FRAME_LOG2  = 4,
  parameter int INIT_THRESH = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  gray_frame_binarizer_if.slave  px,
  output logic                   stat_valid,
  output logic [GRAY_W-1:0]      stat_min,
  output logic [GRAY_W-1:0]      stat_max,
  output logic [GRAY_W-1:0]      stat_mean,
  output logic [15:0]            frame_cnt
);
  localparam logic [GRAY_W-1:0] INIT_T = GRAY_W'(INIT_THRESH);

  state_e            state_q, state_d;
  logic [GRAY_W-1:0] thresh_q, thresh_d;
  logic              out_valid_q, out_valid_d;
  logic [GRAY_W-1:0] out_gray_q, out_gray_d;
  logic [GRAY_W-1:0] out_bin_q, out_bin_d;
  logic              out_last_q, out_last_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              in_ready;
  logic              accept;
  logic              report;
  logic              last;

  gray_frame_stats #(
    .FRAME_LOG2(FRAME_LOG2)
  ) u_stats (
    .clk     (clk),
    .reset   (reset),
    .accept_i(accept),
    .pix_i   (px.in_data),
    .clear_i (report),
    .last_o  (last),
    .min_o   (stat_min),
    .max_o   (stat_max),
    .mean_o  (stat_mean)
  );

  always_comb begin
    state_d     = state_q;
    thresh_d    = thresh_q;
    frame_cnt_d = frame_cnt_q;
    in_ready    = 1'b0;
    accept      = 1'b0;
    report      = 1'b0;
    unique case (state_q)
      ACCUM: begin
        in_ready = !out_valid_q || px.out_ready;
        accept   = px.in_valid && in_ready;
        if (accept && last) state_d = REPORT;
      end
      REPORT: begin
        // One bubble cycle: stats are presented, then the mean becomes the threshold.
        report      = 1'b1;
        thresh_d    = stat_mean;
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = ACCUM;
      end
    endcase

    out_valid_d = out_valid_q;
    out_gray_d  = out_gray_q;
    out_bin_d   = out_bin_q;
    out_last_d  = out_last_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_gray_d  = px.in_data;
      out_bin_d   = (px.in_data >= thresh_q) ? BIN_ON : BIN_OFF;
      out_last_d  = last;
    end else if (out_valid_q && px.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACCUM;
      thresh_q    <= INIT_T;
      frame_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_gray_q  <= '0;
      out_bin_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      thresh_q    <= thresh_d;
      frame_cnt_q <= frame_cnt_d;
      out_valid_q <= out_valid_d;
      out_gray_q  <= out_gray_d;
      out_bin_q   <= out_bin_d;
      out_last_q  <= out_last_d;
    end
  end

  assign px.in_ready  = in_ready;
  assign px.out_valid = out_valid_q;
  assign px.out_gray  = out_gray_q;
  assign px.out_bin   = out_bin_q;
  assign px.out_last  = out_last_q;
  assign stat_valid   = report;
  assign frame_cnt    = frame_cnt_q;
endmodule

// File: tb/tb_gray_frame_binarizer.sv
// tb/tb_gray_frame_binarizer.sv - self-checking bench for gray_frame_binarizer
module tb_gray_frame_binarizer;
  localparam int FL   = 2;
  localparam int NPIX = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        stat_valid;
  logic [7:0]  stat_min, stat_max, stat_mean;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  gray_frame_binarizer_if px();

  gray_frame_binarizer #(
    .FRAME_LOG2 (FL),
    .INIT_THRESH(128)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .px        (px),
    .stat_valid(stat_valid),
    .stat_min  (stat_min),
    .stat_max  (stat_max),
    .stat_mean (stat_mean),
    .frame_cnt (frame_cnt)
  );

  typedef struct {
    logic [7:0] gray;
    logic [7:0] bin;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   frame_pix[$];
  int   thresh;
  int   nframes;
  bit   pending;
  int   e_min, e_max, e_mean;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    frame_pix.delete();
    thresh  = 128;
    nframes = 0;
    pending = 1'b0;
  endtask

  task automatic reset_checks();
    chk("rst_out_valid", px.out_valid, 0);
    chk("rst_out_gray", px.out_gray, 0);
    chk("rst_out_bin", px.out_bin, 0);
    chk("rst_out_last", px.out_last, 0);
    chk("rst_stat_valid", stat_valid, 0);
    chk("rst_stat_min", stat_min, 0);
    chk("rst_stat_max", stat_max, 0);
    chk("rst_stat_mean", stat_mean, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
  endtask

  task automatic do_reset();
    px.in_valid  = 1'b0;
    px.in_data   = 8'd0;
    px.out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    #1;
    reset_checks();
  endtask

  // One clock: drive at the falling edge, sample, step the model at the rising edge.
  task automatic tick(input logic v, input logic [7:0] d, input logic r, output bit acc);
    exp_t e;
    bit   drn;
    int   sum;
    px.in_valid  = v;
    px.in_data   = d;
    px.out_ready = r;
    #1;
    chk("in_ready", px.in_ready, !pending && (exp_q.size() == 0 || r));
    chk("out_valid", px.out_valid, exp_q.size() != 0);
    chk("stat_valid", stat_valid, pending);
    chk("frame_cnt", frame_cnt, nframes & 32'hFFFF);
    if (pending) begin
      chk("stat_min", stat_min, e_min);
      chk("stat_max", stat_max, e_max);
      chk("stat_mean", stat_mean, e_mean);
    end
    acc = v && px.in_ready;
    drn = px.out_valid && r;
    if (drn && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("out_gray", px.out_gray, e.gray);
      chk("out_bin", px.out_bin, e.bin);
      chk("out_last", px.out_last, e.last);
    end
    @(posedge clk);
    if (pending) begin
      thresh  = e_mean;
      nframes = nframes + 1;
      pending = 1'b0;
    end else if (acc) begin
      e.gray = d;
      e.bin  = (d >= thresh) ? 8'hFF : 8'h00;
      e.last = (frame_pix.size() == NPIX - 1);
      exp_q.push_back(e);
      frame_pix.push_back(d);
      if (frame_pix.size() == NPIX) begin
        e_min = 255;
        e_max = 0;
        sum   = 0;
        foreach (frame_pix[i]) begin
          if (frame_pix[i] < e_min) e_min = frame_pix[i];
          if (frame_pix[i] > e_max) e_max = frame_pix[i];
          sum += frame_pix[i];
        end
        e_mean  = sum / NPIX;
        pending = 1'b1;
        frame_pix.delete();
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input bit rnd, inout int rejects);
    bit   acc;
    logic r;
    int   n = 0;
    do begin
      r = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick(1'b1, d, r, acc);
      if (!acc) rejects++;
      n++;
    end while (!acc && n < 50);
    chk("send_timeout", acc, 1);
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    while ((exp_q.size() != 0 || pending) && n < 50) begin
      tick(1'b0, 8'd0, 1'b1, acc);
      n++;
    end
    chk("drain_done", (exp_q.size() == 0) && !pending, 1);
  endtask

  initial begin
    int   rej;
    bit   acc;
    logic [7:0] f1[4] = '{8'd10, 8'd20, 8'd30, 8'd40};
    logic [7:0] f2[4] = '{8'd24, 8'd25, 8'd26, 8'd200};
    logic [7:0] f3[4] = '{8'd0, 8'd0, 8'd0, 8'd4};
    logic [7:0] f4[4] = '{8'd199, 8'd200, 8'd255, 8'd0};

    rej = 0;
    model_clear();
    px.in_valid  = 1'b0;
    px.in_data   = 8'd0;
    px.out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    foreach (f1[i]) send(f1[i], 1'b0, rej);
    drain();
    foreach (f2[i]) send(f2[i], 1'b0, rej);
    drain();

    // Backpressure: first pixel accepted with out_ready low, then held for 5 cycles.
    tick(1'b1, 8'd100, 1'b0, acc);
    chk("bp_first_accept", acc, 1);
    repeat (5) begin
      tick(1'b1, 8'd50, 1'b0, acc);
      chk("bp_blocked", acc, 0);
      #1;
      chk("bp_hold_gray", px.out_gray, 100);
    end
    send(8'd50, 1'b0, rej);
    send(8'd70, 1'b0, rej);
    send(8'd68, 1'b0, rej);
    drain();

    rej = 0;
    for (int i = 0; i < 2 * NPIX; i++) send(8'($urandom_range(0, 255)), 1'b0, rej);
    chk("boundary_bubbles", rej, 1);
    drain();

    send(8'd255, 1'b0, rej);
    send(8'd255, 1'b0, rej);
    do_reset();
    repeat (3) tick(1'b0, 8'd0, 1'b1, acc);
    foreach (f3[i]) send(f3[i], 1'b0, rej);
    drain();

    do_reset();
    repeat (NPIX) send(8'd200, 1'b0, rej);
    drain();
    foreach (f4[i]) send(f4[i], 1'b0, rej);
    drain();

    for (int f = 0; f < 6 * NPIX; f++) begin
      if ($urandom_range(0, 3) == 0) tick(1'b0, 8'd0, ($urandom_range(0, 1) == 1), acc);
      send(8'($urandom_range(0, 255)), 1'b1, rej);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
